regfile_write_sequencer: RTL

Initiator side of the register-file write port. It accepts execution results over a valid/ready stream, assembles vector results from 24-bit lane beats into 192-bit words, and buffers completed writes in a small FIFO. It drains one write per cycle onto the register file's Reg_write/desType/A3/wd3e/wd3v inputs. It sits between the execute stage and the register file, and can report whether a given register still has a write pending.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 83 ++++++++
 rtl/regfile_write_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
//   SCALAR_W / LANE_W / LANES / VEC_W : data widths
//   NREGS / AW                        : register index range and address width
//   dest_type_e                       : destination bank (scalar or vector)
//   wb_entry_t                        : one completed write; scalar data sits in data[SCALAR_W-1:0]
package regfile_pkg;
    localparam int SCALAR_W = 21;
    localparam int LANE_W   = 24;
    localparam int LANES    = 8;
    localparam int VEC_W    = LANES * LANE_W;
    localparam int NREGS    = 6;
    localparam int AW       = 3;
    localparam int LANE_CW  = $clog2(LANES);

    typedef enum logic {
        DEST_SCALAR = 1'b0,
        DEST_VECTOR = 1'b1
    } dest_type_e;

    typedef struct packed {
        dest_type_e       typ;
        logic [AW-1:0]    dest;
        logic [VEC_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Completed-write FIFO between the result assembler and the register-file drain.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of all entries
//   push, push_entry  : enqueue (caller guarantees !full)
//   pop, head         : dequeue; head is the oldest entry (valid when !empty)
//   full, empty, count: occupancy status
//   entries, valid    : raw storage and per-slot valid bits, for hazard matching
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    output wb_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output wb_entry_t [DEPTH-1:0]   entries,
    output logic [DEPTH-1:0]        valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic [DEPTH-1:0]      vld;
    logic [DEPTH-1:0]      vld_nxt;

    always_comb begin
        vld_nxt = vld;
        if (pop)
            vld_nxt[rd_ptr] = 1'b0;
        if (push)
            vld_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            vld <= vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_entry;
    end

    assign head    = mem[rd_ptr];
    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign entries = mem;
    assign valid   = vld;
endmodule

// File: rtl/regfile_write_sequencer.sv
// Initiator side of the register-file write port.
// Accepts scalar results and lane-serial vector results over a valid/ready
// stream, assembles vectors into VEC_W-bit words, queues completed writes in
// wb_fifo and drains one write per cycle onto Reg_write/desType/A3/wd3e/wd3v.
// Ports:
//   in_valid/in_ready/in_type/in_dest/in_data/in_last : result beat stream
//   flush                                             : discard queued and partial writes
//   Reg_write/desType/A3/wd3e/wd3v                    : registered register-file write port
//   q_addr/q_type/q_pending                           : pending-write hazard query
//   count                                             : FIFO occupancy
//   err_bad_addr                                      : registered pulse, write dropped (dest >= NREGS)
// Configuration macro: WSEQ_HAZARD_EN builds the q_pending match logic;
// when undefined q_pending is tied 0.
module regfile_write_sequencer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_type,
    input  logic [AW-1:0]          in_dest,
    input  logic [LANE_W-1:0]      in_data,
    input  logic                   in_last,
    input  logic                   flush,
    output logic                   Reg_write,
    output logic                   desType,
    output logic [AW-1:0]          A3,
    output logic [SCALAR_W-1:0]    wd3e,
    output logic [VEC_W-1:0]       wd3v,
    input  logic [AW-1:0]          q_addr,
    input  logic                   q_type,
    output logic                   q_pending,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_bad_addr
);
    typedef enum logic {
        ASM_IDLE     = 1'b0,
        ASM_ASSEMBLE = 1'b1
    } asm_state_e;

    localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(LANES - 1);
    localparam logic [AW:0]        NREGS_C   = (AW + 1)'(NREGS);

    asm_state_e            state, state_nxt;
    logic [LANE_CW-1:0]    lane, lane_nxt;
    logic [AW-1:0]         asm_dest, asm_dest_nxt;
    logic [VEC_W-1:0]      asm_buf, asm_buf_nxt;
    logic [VEC_W-1:0]      merged;

    logic                  accept;
    logic                  complete;
    dest_type_e            cmp_typ;
    logic [AW-1:0]         cmp_dest;
    logic [VEC_W-1:0]      cmp_data;
    logic                  bad_dest;
    logic                  push;
    wb_entry_t             push_entry;
    logic                  pop;

    wb_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    wb_entry_t [DEPTH-1:0] fifo_entries;
    logic [DEPTH-1:0]      fifo_valid;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ASM_IDLE;
            lane     <= '0;
            asm_dest <= '0;
            asm_buf  <= '0;
        end else begin
            state    <= state_nxt;
            lane     <= lane_nxt;
            asm_dest <= asm_dest_nxt;
            asm_buf  <= asm_buf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lane_nxt     = lane;
        asm_dest_nxt = asm_dest;
        asm_buf_nxt  = asm_buf;
        merged       = asm_buf;
        complete     = 1'b0;
        cmp_typ      = DEST_SCALAR;
        cmp_dest     = '0;
        cmp_data     = '0;

        if (flush) begin
            state_nxt    = ASM_IDLE;
            lane_nxt     = '0;
            asm_dest_nxt = '0;
            asm_buf_nxt  = '0;
        end else if (accept) begin
            case (state)
                ASM_IDLE: begin
                    if (!in_type) begin
                        complete = 1'b1;
                        cmp_typ  = DEST_SCALAR;
                        cmp_dest = in_dest;
                        cmp_data = VEC_W'(in_data[SCALAR_W-1:0]);
                    end else if (in_last) begin
                        // Single-lane vector completes without entering ASSEMBLE.
                        complete = 1'b1;
                        cmp_typ  = DEST_VECTOR;
                        cmp_dest = in_dest;
                        cmp_data = VEC_W'(in_data);
                    end else begin
                        state_nxt    = ASM_ASSEMBLE;
                        lane_nxt     = LANE_CW'(1);
                        asm_dest_nxt = in_dest;
                        asm_buf_nxt  = VEC_W'(in_data);
                    end
                end
                ASM_ASSEMBLE: begin
                    merged[lane*LANE_W +: LANE_W] = in_data;
                    if (in_last || lane == LAST_LANE) begin
                        complete    = 1'b1;
                        cmp_typ     = DEST_VECTOR;
                        cmp_dest    = asm_dest;
                        cmp_data    = merged;
                        state_nxt   = ASM_IDLE;
                        lane_nxt    = '0;
                        asm_buf_nxt = '0;
                    end else begin
                        lane_nxt    = lane + 1'b1;
                        asm_buf_nxt = merged;
                    end
                end
                default: begin
                    state_nxt = ASM_IDLE;
                    lane_nxt  = '0;
                end
            endcase
        end
    end

    assign bad_dest   = complete && ({1'b0, cmp_dest} >= NREGS_C);
    assign push       = complete && !bad_dest;
    assign push_entry = '{typ: cmp_typ, dest: cmp_dest, data: cmp_data};
    assign pop        = !fifo_empty && !flush;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (count),
        .entries    (fifo_entries),
        .valid      (fifo_valid)
    );

    // Output stage: drives a strobe only in the cycle after a pop, otherwise all zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Reg_write    <= 1'b0;
            desType      <= 1'b0;
            A3           <= '0;
            wd3e         <= '0;
            wd3v         <= '0;
            err_bad_addr <= 1'b0;
        end else begin
            err_bad_addr <= bad_dest;
            if (pop) begin
                Reg_write <= 1'b1;
                desType   <= (head.typ == DEST_VECTOR);
                A3        <= head.dest;
                wd3e      <= (head.typ == DEST_SCALAR) ? head.data[SCALAR_W-1:0] : '0;
                wd3v      <= (head.typ == DEST_VECTOR) ? head.data : '0;
            end else begin
                Reg_write <= 1'b0;
                desType   <= 1'b0;
                A3        <= '0;
                wd3e      <= '0;
                wd3v      <= '0;
            end
        end
    end

`ifdef WSEQ_HAZARD_EN
    logic unused_hz_data;
    assign unused_hz_data = ^fifo_entries;

    always_comb begin
        q_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_entries[i].typ == dest_type_e'(q_type)) &&
                (fifo_entries[i].dest == q_addr))
                q_pending = 1'b1;
        end
        if (Reg_write && (desType == q_type) && (A3 == q_addr))
            q_pending = 1'b1;
        if ((state == ASM_ASSEMBLE) && q_type && (asm_dest == q_addr))
            q_pending = 1'b1;
    end
`else
    logic unused_hz;
    assign unused_hz = ^{q_addr, q_type, fifo_entries, fifo_valid};
    assign q_pending = 1'b0;
`endif
endmodule
